rotary_encoder_ctrl: RTL and testbench

- Controller/scheduler for NCH rotary_encoder counter instances in the LiteX rotary-encoder design.
- Preloads counters on CPU request via the encoder din/load path.
- Detects count changes, computes wrap-aware delta and direction, and reports one change event at a time over a valid/ready stream with round-robin fairness.
- Drives a level IRQ toward the CSR/event block.

---
 rtl/rotary_encoder_pkg.sv | 35 +++
 rtl/renc_rr_arbiter.sv | 39 +++
 rtl/rotary_encoder_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rotary_encoder_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_encoder_pkg.sv
// Shared definitions for the rotary encoder controller.
//   - Default channel count / counter width and the channel index width.
//   - Controller FSM state type.
//   - Wrap-aware delta and direction helpers for W-bit counters.
package rotary_encoder_pkg;

    localparam int unsigned NchDef = 4;
    localparam int unsigned WDef   = 5;
    localparam int unsigned ChanW  = $clog2(NchDef);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLoad,
        StSettle,
        StReport
    } state_t;

    // (snap - last) mod 2^w, returned zero-extended to 32 bits.
    function automatic logic [31:0] wrap_delta(input logic [31:0] snap,
                                               input logic [31:0] last,
                                               input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (snap - last) & mask;
    endfunction

    // Increment when the delta is at most half the range; the exact half-range
    // step is ambiguous and is reported as an increment.
    function automatic logic wrap_dir(input logic [31:0] delta,
                                      input int unsigned w);
        return delta <= (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/renc_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : pending request vector, one bit per channel.
//   ptr_i   : highest-priority channel (must be < NCH).
//   gnt_o   : one-hot grant of the first request at or after ptr_i, wrapping.
//   idx_o   : index of the granted channel.
//   valid_o : at least one request present.
module renc_rr_arbiter
    import rotary_encoder_pkg::*;
#(
    parameter int unsigned NCH = NchDef,
    parameter int unsigned CW  = ChanW
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  idx_o,
    output logic           valid_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = CW'(j);
            end
        end
    end

endmodule

// File: rtl/rotary_encoder_ctrl.sv
// Rotary encoder controller / scheduler.
// Preloads encoder counters on CPU request, tracks count changes per channel and
// reports one change event at a time (round-robin) with a wrap-aware delta.
//   clk_i, reset_i        : clock, asynchronous active-high reset.
//   enc_count_i           : encoder counts, lane i = bits [i*W +: W].
//   enc_din_o, enc_load_o : preload values and one-cycle load strobes.
//   enable_i              : per-channel event enable.
//   cfg_*                 : preload request stream (valid/ready).
//   evt_*                 : change event stream (valid/ready) with payload.
//   irq_o                 : level interrupt, equals evt_valid_o.
module rotary_encoder_ctrl
    import rotary_encoder_pkg::*;
#(
    parameter int unsigned NCH             = NchDef,
    parameter int unsigned W               = WDef,
    parameter logic [W-1:0] PRELOAD_DEFAULT = {W{1'b1}},
    // Must be at least 1.
    parameter int unsigned SETTLE          = 2,
    localparam int unsigned CW             = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [NCH*W-1:0] enc_count_i,
    output logic [NCH*W-1:0] enc_din_o,
    output logic [NCH-1:0]   enc_load_o,
    input  logic [NCH-1:0]   enable_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CW-1:0]    cfg_chan_i,
    input  logic [W-1:0]     cfg_value_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CW-1:0]    evt_chan_o,
    output logic [W-1:0]     evt_count_o,
    output logic [W-1:0]     evt_delta_o,
    output logic             evt_dir_o,
    output logic             irq_o
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t                  state_q, state_d;
    logic [CW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [NCH-1:0]          pend_q, pend_d;
    logic [NCH-1:0][W-1:0]   last_q, last_d;
    logic [NCH-1:0][W-1:0]   din_q, din_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [CW-1:0]           evt_chan_q, evt_chan_d;
    logic [W-1:0]            evt_count_q, evt_count_d;
    logic [W-1:0]            evt_delta_q, evt_delta_d;
    logic                    evt_dir_q, evt_dir_d;

    logic [NCH-1:0][W-1:0]   cnt;
    logic [NCH-1:0]          masked;
    logic [NCH-1:0]          gnt;
    logic [CW-1:0]           gidx;
    logic                    gvalid;
    logic [W-1:0]            snap;

    assign cnt = enc_count_i;

    renc_rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req_i   (pend_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .valid_o (gvalid)
    );

    // Count of the granted channel, selected with the one-hot grant.
    always_comb begin
        snap = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                snap = snap | cnt[i];
            end
        end
    end

    // A channel being loaded or settling must not raise events from the
    // transient counts the encoder produces around the load.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            masked[i] = ((state_q == StLoad) || (state_q == StSettle)) && (32'(ch_q) == i);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        pend_d      = pend_q;
        last_d      = last_q;
        din_d       = din_q;
        settle_d    = settle_q;
        evt_chan_d  = evt_chan_q;
        evt_count_d = evt_count_q;
        evt_delta_d = evt_delta_q;
        evt_dir_d   = evt_dir_q;

        for (int unsigned i = 0; i < NCH; i++) begin
            if (!enable_i[i]) begin
                // Track the count while disabled so re-enabling is silent.
                last_d[i] = cnt[i];
                pend_d[i] = 1'b0;
            end else if (!masked[i] && (cnt[i] != last_q[i])) begin
                pend_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            StInit: begin
                last_d  = cnt;
                pend_d  = '0;
                state_d = StIdle;
            end
            StIdle: begin
                if (cfg_valid_i) begin
                    if (32'(cfg_chan_i) < NCH) begin
                        ch_d              = cfg_chan_i;
                        // Written on acceptance so din is valid while the strobe is high.
                        din_d[cfg_chan_i] = cfg_value_i;
                        state_d           = StLoad;
                    end
                end else if (gvalid) begin
                    ch_d        = gidx;
                    evt_chan_d  = gidx;
                    evt_count_d = snap;
                    evt_delta_d = W'(wrap_delta(32'(snap), 32'(last_q[gidx]), W));
                    evt_dir_d   = wrap_dir(wrap_delta(32'(snap), 32'(last_q[gidx]), W), W);
                    state_d     = StReport;
                end
            end
            StLoad: begin
                last_d[ch_q] = din_q[ch_q];
                pend_d[ch_q] = 1'b0;
                settle_d     = SW'(SETTLE - 1);
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_q == '0) begin
                    last_d[ch_q] = cnt[ch_q];
                    state_d      = StIdle;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StReport: begin
                if (evt_ready_i) begin
                    last_d[ch_q] = evt_count_q;
                    pend_d[ch_q] = 1'b0;
                    ptr_d        = (32'(ch_q) == NCH - 1) ? '0 : ch_q + 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StInit;
            ptr_q       <= '0;
            ch_q        <= '0;
            pend_q      <= '0;
            last_q      <= '0;
            din_q       <= {NCH{PRELOAD_DEFAULT}};
            settle_q    <= '0;
            evt_chan_q  <= '0;
            evt_count_q <= '0;
            evt_delta_q <= '0;
            evt_dir_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            pend_q      <= pend_d;
            last_q      <= last_d;
            din_q       <= din_d;
            settle_q    <= settle_d;
            evt_chan_q  <= evt_chan_d;
            evt_count_q <= evt_count_d;
            evt_delta_q <= evt_delta_d;
            evt_dir_q   <= evt_dir_d;
        end
    end

    // Strobes and handshake flags decode the state directly so reset clears them at once.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            enc_load_o[i] = (state_q == StLoad) && (32'(ch_q) == i);
        end
    end

    assign enc_din_o   = din_q;
    assign cfg_ready_o = (state_q == StIdle);
    assign evt_valid_o = (state_q == StReport);
    assign irq_o       = evt_valid_o;
    assign evt_chan_o  = evt_chan_q;
    assign evt_count_o = evt_count_q;
    assign evt_delta_o = evt_delta_q;
    assign evt_dir_o   = evt_dir_q;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Self-checking bench for rotary_encoder_ctrl (NCH=4, W=5).
module tb_rotary_encoder_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] enc_count;
    logic [19:0] enc_din;
    logic [3:0]  enc_load;
    logic [3:0]  enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [4:0]  cfg_value;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_chan;
    logic [4:0]  evt_count;
    logic [4:0]  evt_delta;
    logic        evt_dir;
    logic        irq;

    logic [4:0]  cnt [4];
    int          ref_last [4];
    int          ptr_m;
    int          n_checks = 0;
    int          n_err    = 0;

    assign enc_count = {cnt[3], cnt[2], cnt[1], cnt[0]};

    always #5 clk = ~clk;

    rotary_encoder_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enc_count_i (enc_count),
        .enc_din_o   (enc_din),
        .enc_load_o  (enc_load),
        .enable_i    (enable),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_chan_i  (cfg_chan),
        .cfg_value_i (cfg_value),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_chan_o  (evt_chan),
        .evt_count_o (evt_count),
        .evt_delta_o (evt_delta),
        .evt_dir_o   (evt_dir),
        .irq_o       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Direction from the signed reading of the step; the exact half-range
    // step counts as forward.
    function automatic int ref_dir(input int d);
        int s;
        s = d;
        if (s > 16) s = s - 32;
        return (s >= 0) ? 1 : 0;
    endfunction

    function automatic int ref_delta(input int now_v, input int prev_v);
        return (now_v - prev_v + 32) % 32;
    endfunction

    task automatic wait_evt(input string tag);
        for (int i = 0; i < 20 && !evt_valid; i++) @(negedge clk);
        chk(tag, 32'(evt_valid), 32'd1);
    endtask

    task automatic no_evt(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (evt_valid) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic check_payload(input string tag, input int ch, input int cv,
                                 input int dl, input int dr);
        chk({tag, "_chan"}, 32'(evt_chan), ch);
        chk({tag, "_count"}, 32'(evt_count), cv);
        chk({tag, "_delta"}, 32'(evt_delta), dl);
        chk({tag, "_dir"}, 32'(evt_dir), dr);
        chk({tag, "_irq"}, 32'(irq), 32'd1);
    endtask

    // Handshake at the next edge, then confirm the event dropped.
    task automatic finish_evt(input string tag, input int ch, input int cv);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk({tag, "_drop"}, 32'({evt_valid, irq}), 32'd0);
        ref_last[ch] = cv;
        ptr_m = (ch + 1) % 4;
    endtask

    task automatic expect_event(input string tag, input int ch, input int cv,
                                input int dl, input int dr, input int hold);
        logic [12:0] snap_exp;
        wait_evt({tag, "_wait"});
        check_payload(tag, ch, cv, dl, dr);
        snap_exp = {1'b1, 2'(ch), 5'(cv), 5'(dl)};
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_stable"}, 32'({evt_valid, evt_chan, evt_count, evt_delta}),
                32'(snap_exp));
        end
        finish_evt(tag, ch, cv);
    endtask

    initial begin
        logic        chg [4];
        int          nv [4];
        int          p0;
        int          d;
        logic        seen;

        reset     = 1'b1;
        enable    = 4'hF;
        cfg_valid = 1'b0;
        cfg_chan  = 2'd0;
        cfg_value = 5'd0;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 5'd31;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_din", 32'(enc_din), 32'hFFFFF);
        chk("rst_load", 32'(enc_load), 32'd0);
        chk("rst_flags", 32'({cfg_ready, evt_valid, irq}), 32'd0);
        chk("rst_payload", 32'({evt_chan, evt_count, evt_delta, evt_dir}), 32'd0);
        reset = 1'b0;
        #1;
        chk("init_cfg_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("idle_din", 32'(enc_din), 32'hFFFFF);
        for (int i = 0; i < 4; i++) ref_last[i] = 31;
        ptr_m = 0;
        no_evt("init_no_evt", 5);

        // Ch1 31 -> 3, two-cycle latency, held for 10 cycles.
        cnt[1] = 5'd3;
        @(negedge clk);
        chk("lat_1cyc", 32'(evt_valid), 32'd0);
        @(negedge clk);
        chk("lat_2cyc", 32'(evt_valid), 32'd1);
        chk("report_cfg_ready", 32'(cfg_ready), 32'd0);
        expect_event("ch1", 1, 3, 4, 1, 10);

        // Bring the pointer back to 0 through ch3.
        cnt[3] = 5'd1;
        expect_event("ch3a", 3, 1, 2, 1, 0);

        // Simultaneous ch0 and ch2 with pointer 0.
        cnt[0] = 5'd30;
        cnt[2] = 5'd0;
        expect_event("ch0a", 0, 30, 31, 0, 1);
        expect_event("ch2a", 2, 0, 1, 1, 0);

        // Pointer now 3: ch3 must beat ch0.
        cnt[0] = 5'd28;
        cnt[3] = 5'd2;
        expect_event("ptr3_ch3", 3, 2, 1, 1, 0);
        expect_event("ptr3_ch0", 0, 28, 30, 0, 0);

        // Preload ch3 while it is pending behind a ch1 report.
        cnt[1] = 5'd4;
        wait_evt("cfg_wait");
        check_payload("cfg_ch1", 1, 4, 1, 1);
        cnt[3] = 5'd7;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd3;
        cfg_value = 5'd10;
        repeat (2) @(negedge clk);
        chk("cfg_blocked", 32'(cfg_ready), 32'd0);
        finish_evt("cfg_ch1", 1, 4);
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("load_strobe", 32'(enc_load), 32'h8);
        chk("load_din3", 32'(enc_din[19:15]), 32'd10);
        chk("load_no_evt", 32'(evt_valid), 32'd0);
        cnt[3] = enc_din[19:15];
        @(negedge clk);
        chk("load_one_cycle", 32'(enc_load), 32'd0);
        chk("load_din3_held", 32'(enc_din[19:15]), 32'd10);
        ref_last[3] = 10;
        no_evt("load_no_ch3_evt", 10);

        // Disabled channel tracks silently.
        enable[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cnt[2] = cnt[2] + 5'd3;
            @(negedge clk);
        end
        no_evt("dis_no_evt", 4);
        enable[2] = 1'b1;
        ref_last[2] = int'(cnt[2]);
        no_evt("reen_no_evt", 4);
        cnt[2] = cnt[2] + 5'd1;
        expect_event("reen_step", 2, ref_last[2] + 1, 1, 1, 0);

        // Random multi-channel bursts against the model.
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < 4; c++) begin
                chg[c] = ($urandom_range(0, 1) == 1);
                d = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(1, 31));
                nv[c] = (ref_last[c] + d) % 32;
            end
            if (!(chg[0] || chg[1] || chg[2] || chg[3])) chg[it % 4] = 1'b1;
            for (int c = 0; c < 4; c++) if (chg[c]) cnt[c] = 5'(nv[c]);
            p0 = ptr_m;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (p0 + k) % 4;
                if (chg[c]) begin
                    d = ref_delta(nv[c], ref_last[c]);
                    expect_event("rand", c, nv[c], d, ref_dir(d),
                                 int'($urandom_range(0, 3)));
                end
            end
        end
        no_evt("rand_quiet", 4);

        // Asynchronous reset in the middle of a report.
        cnt[0] = cnt[0] + 5'd2;
        wait_evt("rst_mid_wait");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_flags", 32'({evt_valid, irq, cfg_ready}), 32'd0);
        chk("rst_mid_load", 32'(enc_load), 32'd0);
        chk("rst_mid_din", 32'(enc_din), 32'hFFFFF);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_init", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk("rst2_idle", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 4; i++) ref_last[i] = int'(cnt[i]);
        ptr_m = 0;
        seen = 1'b0;
        no_evt("rst2_no_evt", 5);
        cnt[1] = cnt[1] + 5'd1;
        expect_event("rst2_step", 1, (ref_last[1] + 1) % 32, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
